// File: rtl/i_cache_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// i_cache_axi_rd_bridge
//   Miss-side refill port of the instruction cache. A level request from the
//   i-cache (cache_read_ena / cache_addr) becomes one single-beat, 8-byte AXI4
//   read. The addressed 32-bit half of the returned 64-bit beat is registered
//   onto cache_or_data and announced with a one-cycle cache_in_ok pulse.
//   Only one transaction is ever outstanding.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   cache_read_ena      : refill request, held by the cache until after cache_in_ok
//   cache_addr          : instruction byte address of the miss
//   cache_or_data       : fetched instruction word (registered)
//   cache_in_ok         : one-cycle pulse, cache_or_data valid
//   cache_rd_err        : one-cycle pulse alongside cache_in_ok when RRESP != OKAY
//   m_axi_ar*           : AXI4 read-address channel (master side)
//   m_axi_r*            : AXI4 read-data channel (master side)
// -----------------------------------------------------------------------------
module i_cache_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cache_read_ena,
    input  logic [ADDR_W-1:0] cache_addr,
    output logic [31:0]       cache_or_data,
    output logic              cache_in_ok,
    output logic              cache_rd_err,

    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [3:0]        m_axi_arid,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,

    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_DONE  = 3'd3,
        S_REARM = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic                r_err;

    logic                w_capture;
    logic                w_r_hs;
    logic [31:0]         w_word;

    // With arlen=0 every beat is the last one, and the 8-byte aligned
    // address never needs the low two bits of the captured address.
    logic                w_unused;
    assign w_unused = &{1'b0, m_axi_rlast, r_addr[1:0]};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_r_hs      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cache_read_ena) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_AR;
                end
            end
            S_AR: begin
                if (m_axi_arready) w_state_nxt = S_R;
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    w_r_hs      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_REARM;
            end
            S_REARM: begin
                // The cache keeps its request up for a couple of cycles after
                // the ok pulse; waiting for it to drop avoids refilling the
                // same miss twice.
                if (!cache_read_ena) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Half-word select uses the captured address, never the live input.
    assign w_word = r_addr[2] ? m_axi_rdata[63:32] : m_axi_rdata[31:0];

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) r_addr <= cache_addr;
            if (w_r_hs) begin
                r_data <= w_word;
                r_err  <= (m_axi_rresp != 2'b00);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all decoded from registered state, so no AXI input reaches
    // an AXI output combinationally, and arvalid cannot drop before arready.
    // ---------------------------------------------------------------------
    assign m_axi_arvalid = (r_state == S_AR);
    assign m_axi_araddr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign m_axi_arid    = AXI_ID;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = (r_state == S_R);

    assign cache_or_data = r_data;
    assign cache_in_ok   = (r_state == S_DONE);
    assign cache_rd_err  = (r_state == S_DONE) & r_err;

endmodule

// File: tb/tb_i_cache_axi_rd_bridge.sv
module tb_i_cache_axi_rd_bridge;

    logic        clk;
    logic        rst;
    logic        cache_read_ena;
    logic [63:0] cache_addr;
    logic [31:0] cache_or_data;
    logic        cache_in_ok;
    logic        cache_rd_err;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [3:0]  m_axi_arid;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;

    int checks = 0;
    int errors = 0;

    i_cache_axi_rd_bridge #(.AXI_ID(4'd0), .ADDR_W(64), .DATA_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .cache_read_ena (cache_read_ena),
        .cache_addr     (cache_addr),
        .cache_or_data  (cache_or_data),
        .cache_in_ok    (cache_in_ok),
        .cache_rd_err   (cache_rd_err),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arid     (m_axi_arid),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete refill. ar_wait/r_wait: cycles arready/rvalid are held low.
    // addr_late: value put on cache_addr right after capture.
    // hold: cycles cache_read_ena stays high after the ok pulse.
    task automatic txn(input string tag, input logic [63:0] addr, input logic [63:0] addr_late,
                       input int ar_wait, input int r_wait, input int hold,
                       input logic [63:0] rdata, input logic [1:0] rresp,
                       input logic [31:0] exp_word, input logic exp_err);
        logic [63:0] exp_araddr;
        exp_araddr     = {addr[63:3], 3'b000};
        cache_read_ena = 1'b1;
        cache_addr     = addr;
        m_axi_arready  = 1'b0;
        m_axi_rvalid   = 1'b0;
        step();                                  // request captured
        cache_addr = addr_late;
        chk({tag, ".arvalid"}, 64'(m_axi_arvalid), 64'd1);
        chk({tag, ".araddr"},  m_axi_araddr, exp_araddr);
        chk({tag, ".arlen"},   64'(m_axi_arlen), 64'd0);
        chk({tag, ".arsize"},  64'(m_axi_arsize), 64'd3);
        chk({tag, ".arburst"}, 64'(m_axi_arburst), 64'd1);
        chk({tag, ".arid"},    64'(m_axi_arid), 64'd0);
        chk({tag, ".rready_ar"}, 64'(m_axi_rready), 64'd0);
        for (int i = 0; i < ar_wait; i++) begin
            step();
            chk({tag, ".arvalid_hold"}, 64'(m_axi_arvalid), 64'd1);
            chk({tag, ".araddr_hold"},  m_axi_araddr, exp_araddr);
            chk({tag, ".ok_early"},     64'(cache_in_ok), 64'd0);
        end
        m_axi_arready = 1'b1;
        step();                                  // AR handshake
        m_axi_arready = 1'b0;
        chk({tag, ".arvalid_drop"}, 64'(m_axi_arvalid), 64'd0);
        chk({tag, ".rready"},       64'(m_axi_rready), 64'd1);
        for (int i = 0; i < r_wait; i++) begin
            step();
            chk({tag, ".rready_hold"}, 64'(m_axi_rready), 64'd1);
            chk({tag, ".ok_wait"},     64'(cache_in_ok), 64'd0);
        end
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = rdata;
        m_axi_rresp  = rresp;
        step();                                  // R handshake
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        chk({tag, ".ok"},     64'(cache_in_ok), 64'd1);
        chk({tag, ".err"},    64'(cache_rd_err), 64'(exp_err));
        chk({tag, ".data"},   64'(cache_or_data), 64'(exp_word));
        chk({tag, ".rready_drop"}, 64'(m_axi_rready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".ok_dup"},      64'(cache_in_ok), 64'd0);
            chk({tag, ".arvalid_dup"}, 64'(m_axi_arvalid), 64'd0);
        end
        cache_read_ena = 1'b0;
        step();
        chk({tag, ".ok_once"}, 64'(cache_in_ok), 64'd0);
        chk({tag, ".err_once"}, 64'(cache_rd_err), 64'd0);
        chk({tag, ".data_keep"}, 64'(cache_or_data), 64'(exp_word));
        step();
    endtask

    initial begin
        rst            = 1'b0;
        cache_read_ena = 1'b0;
        cache_addr     = '0;
        m_axi_arready  = 1'b0;
        m_axi_rvalid   = 1'b0;
        m_axi_rdata    = '0;
        m_axi_rresp    = 2'b00;
        m_axi_rlast    = 1'b1;
        step();
        step();
        chk("rst.arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst.rready",  64'(m_axi_rready), 64'd0);
        chk("rst.ok",      64'(cache_in_ok), 64'd0);
        chk("rst.err",     64'(cache_rd_err), 64'd0);
        chk("rst.data",    64'(cache_or_data), 64'd0);
        rst = 1'b1;
        step();
        chk("idle.arvalid", 64'(m_axi_arvalid), 64'd0);

        // 1: high half, minimum latency
        txn("t1", 64'h8000_0004, 64'h8000_0004, 0, 0, 0,
            64'h1111_2222_3333_4444, 2'b00, 32'h1111_2222, 1'b0);

        // 2: arready held off 5 cycles, low half
        txn("t2", 64'h8000_0008, 64'h8000_0008, 5, 0, 0,
            64'h0123_4567_DEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);

        // 3: request held 4 cycles after ok, then a fresh request
        txn("t3a", 64'h0000_1000, 64'h0000_1000, 0, 0, 4,
            64'hAAAA_5555_CAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0);
        txn("t3b", 64'h0000_100C, 64'h0000_100C, 0, 0, 0,
            64'h1357_2468_9ABC_DEF0, 2'b00, 32'h1357_2468, 1'b0);

        // 4: SLVERR response still forwards data
        txn("t4", 64'h0000_2004, 64'h0000_2004, 0, 0, 0,
            64'hBAD0_BAD0_0000_0000, 2'b10, 32'hBAD0_BAD0, 1'b1);

        // 5: reset while in R with rvalid pending
        cache_read_ena = 1'b1;
        cache_addr     = 64'h0000_5004;
        step();
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        chk("t5.rready_pre", 64'(m_axi_rready), 64'd1);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 64'h7777_7777_8888_8888;
        rst          = 1'b0;
        step();
        chk("t5.arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("t5.rready",  64'(m_axi_rready), 64'd0);
        chk("t5.ok",      64'(cache_in_ok), 64'd0);
        chk("t5.data",    64'(cache_or_data), 64'd0);
        m_axi_rvalid   = 1'b0;
        cache_read_ena = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t5.no_pulse", 64'(cache_in_ok), 64'd0);
        txn("t5b", 64'h0000_3000, 64'h0000_3000, 0, 0, 0,
            64'h0000_0000_FEED_FACE, 2'b00, 32'hFEED_FACE, 1'b0);

        // 6: slow rvalid, cache_addr flips bit 2 after capture
        txn("t6", 64'h0000_4004, 64'h0000_4000, 0, 10, 0,
            64'h5566_7788_99AA_BBCC, 2'b00, 32'h5566_7788, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
